// File: rtl/string_tape_port_arbiter_pkg.sv
// Shared types and defaults for the string-tape port arbiter.
package string_tape_port_arbiter_pkg;
   localparam int StringTapeLength = 16384;
   localparam int TapeIndexW       = 14;

   typedef logic [TapeIndexW-1:0] tape_index_t;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } arb_state_t;
endpackage

// File: rtl/string_tape_port_arbiter_read_pipe.sv
// Read response pipeline: valid/out-of-range shift registers and output data register.
module string_tape_read_pipe #(
   parameter int READ_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       accept,
   input  logic       out_of_range,
   input  logic [7:0] ram_dob,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy
);
   localparam int Depth = READ_LATENCY + 1;

   logic [Depth-1:0] valid_sr;
   logic [Depth-2:0] oor_sr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_sr <= '0;
         oor_sr   <= '0;
         rsp_data <= '0;
      end else begin
         valid_sr[0] <= accept;
         for (int i = 1; i < Depth; i++) valid_sr[i] <= valid_sr[i-1];
         oor_sr[0] <= out_of_range;
         for (int i = 1; i < Depth - 1; i++) oor_sr[i] <= oor_sr[i-1];
         // ram_dob is valid for the request in stage Depth-2; out-of-range reads never touched the BRAM
         if (valid_sr[Depth-2]) rsp_data <= oor_sr[Depth-2] ? 8'h00 : ram_dob;
      end
   end

   assign rsp_valid = valid_sr[Depth-1];
   assign busy      = |valid_sr;
endmodule

// File: rtl/string_tape_port_arbiter.sv
// Shares the dual-port string-tape BRAM between the accumulator, host readback and the clear engine.
// Optional read/write collision monitor: define STRING_TAPE_ARB_COLLISION_CHECK_EN.
//
// state    | meaning
// ST_CLEAR | zeroing two bytes per cycle, writer ignored, no reads
// ST_RUN   | writer owns port A (and B when w_web), reads use idle port B
module string_tape_port_arbiter
   import string_tape_port_arbiter_pkg::*;
#(
   parameter int NUM_WORDS    = StringTapeLength,
   parameter int ADDR_W       = TapeIndexW,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   output logic              init_done,
   input  logic              w_wea,
   input  logic              w_web,
   input  logic [ADDR_W-1:0] w_addra,
   input  logic [ADDR_W-1:0] w_addrb,
   input  logic [7:0]        w_dia,
   input  logic [7:0]        w_dib,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rsp_valid,
   output logic [7:0]        rsp_data,
   output logic              ram_wea,
   output logic              ram_web,
   output logic [ADDR_W-1:0] ram_addra,
   output logic [ADDR_W-1:0] ram_addrb,
   output logic [7:0]        ram_dia,
   output logic [7:0]        ram_dib,
   input  logic [7:0]        ram_dob,
   output logic              err_write_in_clear,
   output logic              collision
);
   localparam logic [ADDR_W-1:0] LastPair = ADDR_W'(NUM_WORDS - 2);

   arb_state_t        state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic              clear_pending, pending_nxt;
   logic              writer_active, rd_oor, pipe_busy;

   assign writer_active = w_wea | w_web;
   assign rd_oor        = {1'b0, rd_addr} >= (ADDR_W+1)'(NUM_WORDS);
   assign init_done     = (state == ST_RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_CLEAR;
         ptr           <= '0;
         clear_pending <= 1'b0;
      end else begin
         state         <= state_nxt;
         ptr           <= ptr_nxt;
         clear_pending <= pending_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      pending_nxt = clear_pending;
      rd_ready    = 1'b0;
      ram_wea     = 1'b0;
      ram_web     = 1'b0;
      ram_addra   = ptr;
      ram_addrb   = ptr + ADDR_W'(1);
      ram_dia     = 8'h00;
      ram_dib     = 8'h00;
      case (state)
         ST_CLEAR: begin
            ram_wea     = 1'b1;
            ram_web     = 1'b1;
            pending_nxt = 1'b0;
            if (clear) begin
               ptr_nxt = '0;
            end else if (ptr == LastPair) begin
               ptr_nxt   = '0;
               state_nxt = ST_RUN;
            end else begin
               ptr_nxt = ptr + ADDR_W'(2);
            end
         end
         ST_RUN: begin
            ram_wea   = w_wea;
            ram_addra = w_addra;
            ram_dia   = w_dia;
            if (w_web) begin
               ram_web   = 1'b1;
               ram_addrb = w_addrb;
               ram_dib   = w_dib;
            end else begin
               ram_addrb = rd_addr;
               rd_ready  = rd_valid & ~clear_pending;
            end
            if (clear) pending_nxt = 1'b1;
            // the writer cannot be stalled, so wait for it to go idle and for reads to drain
            if (clear_pending && !writer_active && !pipe_busy) begin
               state_nxt   = ST_CLEAR;
               ptr_nxt     = '0;
               pending_nxt = 1'b0;
            end
         end
         default: state_nxt = ST_CLEAR;
      endcase
      if (!rst_n) begin
         ram_wea  = 1'b0;
         ram_web  = 1'b0;
         rd_ready = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) err_write_in_clear <= 1'b0;
      else if (state == ST_CLEAR && writer_active) err_write_in_clear <= 1'b1;
   end

   string_tape_read_pipe #(
      .READ_LATENCY(READ_LATENCY)
   ) u_read_pipe (
      .clk          (clk),
      .rst_n        (rst_n),
      .accept       (rd_ready),
      .out_of_range (rd_oor),
      .ram_dob      (ram_dob),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .busy         (pipe_busy)
   );

`ifdef STRING_TAPE_ARB_COLLISION_CHECK_EN
   logic              prev_wea;
   logic [ADDR_W-1:0] prev_addra;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         collision  <= 1'b0;
         prev_wea   <= 1'b0;
         prev_addra <= '0;
      end else begin
         prev_wea   <= ram_wea;
         prev_addra <= ram_addra;
         if (rd_ready && ((w_wea && w_addra == rd_addr) || (prev_wea && prev_addra == rd_addr)))
            collision <= 1'b1;
      end
   end
`else
   assign collision = 1'b0;
`endif
endmodule

// File: tb/tb_string_tape_port_arbiter.sv
// Bench for string_tape_port_arbiter: directed steps plus random traffic against a byte-array model.
module tb_string_tape_port_arbiter;
   localparam int NW = 16;
   localparam int AW = 5;
`ifdef STRING_TAPE_ARB_COLLISION_CHECK_EN
   localparam bit CollEn = 1'b1;
`else
   localparam bit CollEn = 1'b0;
`endif

   logic          clk, rst_n, clear, init_done;
   logic          w_wea, w_web, rd_valid, rd_ready, rsp_valid;
   logic [AW-1:0] w_addra, w_addrb, rd_addr, ram_addra, ram_addrb;
   logic [7:0]    w_dia, w_dib, rsp_data, ram_dia, ram_dib, ram_dob;
   logic          ram_wea, ram_web, err_write_in_clear, collision;

   string_tape_port_arbiter #(.NUM_WORDS(NW), .ADDR_W(AW), .READ_LATENCY(1)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .init_done(init_done),
      .w_wea(w_wea), .w_web(w_web), .w_addra(w_addra), .w_addrb(w_addrb),
      .w_dia(w_dia), .w_dib(w_dib), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_addr(rd_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .ram_wea(ram_wea), .ram_web(ram_web), .ram_addra(ram_addra), .ram_addrb(ram_addrb),
      .ram_dia(ram_dia), .ram_dib(ram_dib), .ram_dob(ram_dob),
      .err_write_in_clear(err_write_in_clear), .collision(collision));

   // read-first BRAM; the decoder only sees the low bits, so out-of-range reads alias
   logic [7:0] bram [0:15];
   always @(posedge clk) begin
      if (ram_wea) bram[ram_addra[3:0]] <= ram_dia;
      if (ram_web) bram[ram_addrb[3:0]] <= ram_dib;
      ram_dob <= bram[ram_addrb[3:0]];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [7:0] data;
   } exp_t;

   exp_t       rsp_q[$];
   logic [7:0] ref_mem [0:15];
   int         checks = 0, failures = 0, cyc = 0, lowcnt;
   bit         m_open;
   logic       s_wea, s_web, s_init, s_err, s_coll;
   logic [AW-1:0] s_addra, s_addrb;
   logic [7:0] s_dia, s_dib, s_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      clear = 1'b0; w_wea = 1'b0; w_web = 1'b0; rd_valid = 1'b0;
      w_addra = '0; w_addrb = '0; w_dia = '0; w_dib = '0; rd_addr = '0;
   endtask

   // one clock cycle: check handshake/response mid-cycle, then advance the model on the edge
   task automatic tick();
      logic exp_rdy, exp_rv;
      @(negedge clk);
      exp_rdy = m_open && rd_valid && !w_web;
      chk("rd_ready", {31'b0, rd_ready}, {31'b0, exp_rdy});
      exp_rv = rsp_q.size() > 0 && rsp_q[0].due == cyc;
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rv});
      if (exp_rv) begin
         chk("rsp_data", {24'b0, rsp_data}, {24'b0, rsp_q[0].data});
         void'(rsp_q.pop_front());
      end
      s_wea = ram_wea; s_web = ram_web; s_addra = ram_addra; s_addrb = ram_addrb;
      s_dia = ram_dia; s_dib = ram_dib; s_init = init_done; s_err = err_write_in_clear;
      s_coll = collision; s_rdata = rsp_data;
      @(posedge clk);
      if (exp_rdy)
         rsp_q.push_back(exp_t'{cyc + 2, (rd_addr < AW'(NW)) ? ref_mem[rd_addr[3:0]] : 8'h00});
      if (m_open) begin
         if (w_wea) ref_mem[w_addra[3:0]] = w_dia;
         if (w_web) ref_mem[w_addrb[3:0]] = w_dib;
      end
      cyc++;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      m_open = 1'b0;
      idle();
      rst_n = 1'b0;
      rd_valid = 1'b1;
      clear = 1'b1;
      repeat (3) tick();
      chk("rst_wea", {31'b0, s_wea}, 0);
      chk("rst_web", {31'b0, s_web}, 0);
      chk("rst_init_done", {31'b0, s_init}, 0);
      chk("rst_err", {31'b0, s_err}, 0);
      chk("rst_collision", {31'b0, s_coll}, 0);
      chk("rst_rsp_data", {24'b0, s_rdata}, 0);

      // clear sweep after reset release; a stray writer pulse in cycle 3
      rst_n = 1'b1;
      clear = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         w_wea = (k == 3); w_addra = 5'd3; w_dia = 8'hff;
         tick();
         chk("clr_wea", {31'b0, s_wea}, 1);
         chk("clr_web", {31'b0, s_web}, 1);
         chk("clr_addra", {27'b0, s_addra}, 2 * (k - 1));
         chk("clr_addrb", {27'b0, s_addrb}, 2 * k - 1);
         chk("clr_data", {16'b0, s_dia, s_dib}, 0);
         chk("clr_init_done", {31'b0, s_init}, 0);
         chk("clr_err", {31'b0, s_err}, {31'b0, k > 3});
      end
      idle();
      m_open = 1'b1;
      tick();
      chk("init_done_cycle9", {31'b0, s_init}, 1);

      // write 0x41 to 5, read it back two cycles later
      w_wea = 1'b1; w_addra = 5'd5; w_dia = 8'h41; tick();
      idle(); tick();
      rd_valid = 1'b1; rd_addr = 5'd5; tick();
      idle(); repeat (3) tick();

      // port B writer blocks a pending read for three cycles
      rd_valid = 1'b1; rd_addr = 5'd2;
      w_web = 1'b1; w_addrb = 5'd9; w_dib = 8'h5a;
      repeat (3) tick();
      w_web = 1'b0; tick();
      idle(); repeat (3) tick();

      // back-to-back reads, last one out of range
      w_wea = 1'b1; w_addra = 5'd3; w_dia = 8'h33;
      w_web = 1'b1; w_addrb = 5'd4; w_dib = 8'h44; tick();
      idle(); tick();
      rd_valid = 1'b1;
      rd_addr = 5'd3; tick();
      rd_addr = 5'd4; tick();
      rd_addr = 5'd20; tick();
      idle(); repeat (3) tick();

      // read-during-write to 7 returns the old byte
      w_wea = 1'b1; w_addra = 5'd7; w_dia = 8'h77; tick();
      idle(); tick();
      chk("collision_before", {31'b0, s_coll}, 0);
      w_wea = 1'b1; w_addra = 5'd7; w_dia = 8'h99;
      rd_valid = 1'b1; rd_addr = 5'd7; tick();
      idle(); tick();
      chk("collision_after", {31'b0, s_coll}, {31'b0, CollEn});
      repeat (3) tick();

      // random traffic
      for (int i = 0; i < 300; i++) begin
         w_wea    = ($urandom_range(0, 1) == 1);
         w_addra  = AW'($urandom_range(0, 15));
         w_dia    = 8'($urandom);
         w_web    = ($urandom_range(0, 3) == 0);
         w_addrb  = AW'((32'(w_addra) + $urandom_range(1, 15)) % 16);
         w_dib    = 8'($urandom);
         rd_valid = ($urandom_range(0, 2) != 0);
         rd_addr  = AW'($urandom_range(0, 19));
         tick();
      end
      idle(); repeat (4) tick();
      chk("collision_random", {31'b0, s_coll}, {31'b0, CollEn});

      // clear with writer active and one read in flight
      rd_valid = 1'b1; rd_addr = 5'd3; w_wea = 1'b1; w_addra = 5'd8; w_dia = 8'h12; tick();
      rd_valid = 1'b0; clear = 1'b1; tick();
      chk("clr_req_init_done", {31'b0, s_init}, 1);
      clear = 1'b0; m_open = 1'b0; rd_valid = 1'b1; rd_addr = 5'd2;
      repeat (2) begin
         tick();
         chk("pending_writer_busy", {31'b0, s_init}, 1);
      end
      w_wea = 1'b0; tick();
      chk("pending_idle_init_done", {31'b0, s_init}, 1);
      rd_valid = 1'b0;
      lowcnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (!s_init) lowcnt++;
         else if (lowcnt > 0) break;
      end
      chk("clear_low_cycles", lowcnt, 8);
      chk("clear_rsp_drained", rsp_q.size(), 0);
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      m_open = 1'b1;
      rd_valid = 1'b1; rd_addr = 5'd8; tick();
      rd_addr = 5'd3; tick();
      idle(); repeat (3) tick();

      // reset discards an in-flight read
      rd_valid = 1'b1; rd_addr = 5'd1; tick();
      idle(); rst_n = 1'b0; m_open = 1'b0; rsp_q.delete();
      repeat (3) tick();
      chk("rst2_init_done", {31'b0, s_init}, 0);
      chk("rst2_err", {31'b0, s_err}, 0);
      chk("rst2_collision", {31'b0, s_coll}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
